inv_sub_shift_8: RTL and testbench



---
 rtl/aes_dec_pkg.sv | 44 ++++
 rtl/inv_sbox_8.sv | 51 +++++
 rtl/inv_sub_shift_8.sv | 129 ++++++++++++
 tb/tb_inv_sub_shift_8.sv | 381 ++++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/aes_dec_pkg.sv
// Shared constants and helpers for the byte-serial AES-128 decryption datapath.
// Holds the InvShiftRows byte permutation and the inverse affine transform.
package aes_dec_pkg;

    localparam int unsigned IDX_W       = 4;
    localparam int unsigned STATE_BYTES = 16;

    typedef logic [IDX_W-1:0] idx_t;
    typedef logic [7:0]       byte_t;

    localparam idx_t LAST_IDX = idx_t'(STATE_BYTES - 1);

    // Reduction term of the AES field polynomial x^8 + x^4 + x^3 + x + 1.
    localparam byte_t GF_POLY = 8'h1B;

    // Constant stripped before the inverse affine map.
    localparam byte_t INV_AFFINE_C = 8'h63;

    // Row i selects the input bits feeding output bit i (rotl 1 ^ rotl 3 ^ rotl 6).
    localparam logic [7:0][7:0] INV_AFFINE_MAT = {
        8'h52, 8'h29, 8'h94, 8'h4A, 8'h25, 8'h92, 8'h49, 8'hA4
    };

    // Output byte j of InvShiftRows reads state byte r + 4*((c - r) mod 4).
    function automatic idx_t perm(input idx_t j);
        logic [1:0] r;
        logic [1:0] c;
        logic [1:0] src_c;
        r     = j[1:0];
        c     = j[3:2];
        src_c = c - r;
        return {src_c, r};
    endfunction

    function automatic byte_t inv_affine(input byte_t y);
        byte_t res;
        res = '0;
        for (int i = 0; i < 8; i++) begin
            res[i] = ^(y & INV_AFFINE_MAT[i]);
        end
        return res;
    endfunction

endpackage

// File: rtl/inv_sbox_8.sv
// Combinational AES inverse S-box: strip 0x63, apply the inverse affine map,
// then take the multiplicative inverse in GF(2^8).
module inv_sbox_8
    import aes_dec_pkg::*;
(
    input  logic [7:0] x_i,
    output logic [7:0] y_o
);

    function automatic byte_t gf_mul(input byte_t a, input byte_t b);
        byte_t p;
        byte_t t;
        p = '0;
        t = a;
        for (int i = 0; i < 8; i++) begin
            if (b[i]) begin
                p = p ^ t;
            end
            t = {t[6:0], 1'b0} ^ (t[7] ? GF_POLY : 8'h00);
        end
        return p;
    endfunction

    // x^254 == x^-1 for nonzero x, and maps 0 to 0 as AES requires.
    function automatic byte_t gf_inv(input byte_t x);
        byte_t x2;
        byte_t x3;
        byte_t x6;
        byte_t x12;
        byte_t x15;
        byte_t x240;
        x2   = gf_mul(x, x);
        x3   = gf_mul(x2, x);
        x6   = gf_mul(x3, x3);
        x12  = gf_mul(x6, x6);
        x15  = gf_mul(x12, x3);
        x240 = x15;
        for (int i = 0; i < 4; i++) begin
            x240 = gf_mul(x240, x240);
        end
        return gf_mul(gf_mul(x240, x12), x2);
    endfunction

    byte_t affine_out;

    always_comb begin
        affine_out = inv_affine(x_i ^ INV_AFFINE_C);
        y_o        = gf_inv(affine_out);
    end

endmodule

// File: rtl/inv_sub_shift_8.sv
// Byte-serial InvSubBytes + InvShiftRows with two ping-pong state banks.
// Bytes are substituted on the way in and permuted on the way out.
module inv_sub_shift_8
    import aes_dec_pkg::*;
#(
    parameter int unsigned SBOX_PIPE = 0
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       in_valid,
    output logic       in_ready,
    input  logic [7:0] in_data,
    output logic       out_valid,
    input  logic       out_ready,
    output logic [7:0] out_data,
    output logic       out_last
);

    byte_t      sbox_out;
    idx_t       wr_idx_q, wr_idx_d;
    idx_t       rd_idx_q, rd_idx_d;
    logic       wr_bank_q, wr_bank_d;
    logic       rd_bank_q, rd_bank_d;
    logic [1:0] full_q, full_d;
    byte_t      mem_q [2][STATE_BYTES];
    byte_t      mem_d [2][STATE_BYTES];
    logic       pipe_vld_q, pipe_vld_d;
    byte_t      pipe_data_q, pipe_data_d;
    logic       pipe_bank_q, pipe_bank_d;
    idx_t       pipe_idx_q, pipe_idx_d;

    logic       in_fire;
    logic       out_fire;
    logic       we;
    logic       we_bank;
    idx_t       we_idx;
    byte_t      we_data;

    inv_sbox_8 u_inv_sbox (
        .x_i (in_data),
        .y_o (sbox_out)
    );

    always_comb begin
        in_ready  = ~full_q[wr_bank_q];
        out_valid = full_q[rd_bank_q];
        out_data  = out_valid ? mem_q[rd_bank_q][perm(rd_idx_q)] : 8'h00;
        out_last  = out_valid && (rd_idx_q == LAST_IDX);
    end

    assign in_fire  = in_valid & in_ready;
    assign out_fire = out_valid & out_ready;

    always_comb begin
        wr_idx_d  = wr_idx_q;
        wr_bank_d = wr_bank_q;
        if (in_fire) begin
            wr_idx_d = wr_idx_q + idx_t'(1);
            if (wr_idx_q == LAST_IDX) begin
                wr_bank_d = ~wr_bank_q;
            end
        end

        // Slot is reserved at acceptance, so the staged byte always lands.
        pipe_vld_d  = in_fire;
        pipe_data_d = sbox_out;
        pipe_bank_d = wr_bank_q;
        pipe_idx_d  = wr_idx_q;

        if (SBOX_PIPE != 0) begin
            we      = pipe_vld_q;
            we_bank = pipe_bank_q;
            we_idx  = pipe_idx_q;
            we_data = pipe_data_q;
        end else begin
            we      = in_fire;
            we_bank = wr_bank_q;
            we_idx  = wr_idx_q;
            we_data = sbox_out;
        end

        mem_d = mem_q;
        if (we) begin
            mem_d[we_bank][we_idx] = we_data;
        end

        // Fill-complete and drain-complete always target different banks.
        full_d    = full_q;
        rd_idx_d  = rd_idx_q;
        rd_bank_d = rd_bank_q;
        if (we && (we_idx == LAST_IDX)) begin
            full_d[we_bank] = 1'b1;
        end
        if (out_fire) begin
            rd_idx_d = rd_idx_q + idx_t'(1);
            if (rd_idx_q == LAST_IDX) begin
                full_d[rd_bank_q] = 1'b0;
                rd_bank_d         = ~rd_bank_q;
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_idx_q    <= '0;
            rd_idx_q    <= '0;
            wr_bank_q   <= 1'b0;
            rd_bank_q   <= 1'b0;
            full_q      <= '0;
            mem_q       <= '{default: 8'h00};
            pipe_vld_q  <= 1'b0;
            pipe_data_q <= '0;
            pipe_bank_q <= 1'b0;
            pipe_idx_q  <= '0;
        end else begin
            wr_idx_q    <= wr_idx_d;
            rd_idx_q    <= rd_idx_d;
            wr_bank_q   <= wr_bank_d;
            rd_bank_q   <= rd_bank_d;
            full_q      <= full_d;
            mem_q       <= mem_d;
            pipe_vld_q  <= pipe_vld_d;
            pipe_data_q <= pipe_data_d;
            pipe_bank_q <= pipe_bank_d;
            pipe_idx_q  <= pipe_idx_d;
        end
    end

endmodule

// File: tb/tb_inv_sub_shift_8.sv
// Bench for inv_sub_shift_8: both SBOX_PIPE variants are driven in turn and
// compared against a table-driven InvSubBytes/InvShiftRows model.
module tb_inv_sub_shift_8;

    logic       clk;
    logic       rst;
    logic       in_valid  [2];
    logic       in_ready  [2];
    logic [7:0] in_data   [2];
    logic       out_valid [2];
    logic       out_ready [2];
    logic [7:0] out_data  [2];
    logic       out_last  [2];

    int n_pass  = 0;
    int n_total = 0;

    logic [7:0] inv_tab [256];
    logic [7:0] exp_q [$];
    logic [7:0] in_buf [$];

    logic [7:0] known_in  [16];
    logic [7:0] known_exp [16];
    logic [7:0] zero_in   [16];
    logic [7:0] zero_exp  [16];

    initial clk = 1'b0;
    always #5 clk = ~clk;

    for (genvar g = 0; g < 2; g++) begin : g_dut
        inv_sub_shift_8 #(
            .SBOX_PIPE (g)
        ) u_dut (
            .clk       (clk),
            .rst       (rst),
            .in_valid  (in_valid[g]),
            .in_ready  (in_ready[g]),
            .in_data   (in_data[g]),
            .out_valid (out_valid[g]),
            .out_ready (out_ready[g]),
            .out_data  (out_data[g]),
            .out_last  (out_last[g])
        );
    end

    function automatic logic [7:0] gmul(input logic [7:0] a, input logic [7:0] b);
        int prod;
        prod = 0;
        for (int i = 0; i < 8; i++) begin
            if (b[i]) prod = prod ^ (int'(a) << i);
        end
        for (int i = 14; i >= 8; i--) begin
            if (prod[i]) prod = prod ^ (32'h11B << (i - 8));
        end
        return prod[7:0];
    endfunction

    function automatic logic [7:0] rotl(input logic [7:0] v, input int k);
        logic [15:0] w;
        w = {v, v} << k;
        return w[15:8];
    endfunction

    // Forward S-box from its definition, then inverted into a lookup table.
    task automatic build_tables();
        logic [7:0] inv;
        logic [7:0] s;
        for (int x = 0; x < 256; x++) begin
            inv = 8'h00;
            for (int y = 1; y < 256; y++) begin
                if (gmul(8'(x), 8'(y)) == 8'h01) inv = 8'(y);
            end
            s = inv ^ rotl(inv, 1) ^ rotl(inv, 2) ^ rotl(inv, 3) ^ rotl(inv, 4) ^ 8'h63;
            inv_tab[s] = 8'(x);
        end
    endtask

    // Collect a frame; when complete, queue its InvShiftRows(InvSubBytes(.)) bytes.
    task automatic model_accept(input logic [7:0] b);
        int r;
        int c;
        in_buf.push_back(b);
        if (in_buf.size() == 16) begin
            for (int j = 0; j < 16; j++) begin
                r = j % 4;
                c = j / 4;
                exp_q.push_back(inv_tab[in_buf[r + 4 * ((c - r + 4) % 4)]]);
            end
            in_buf.delete();
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset(input int sel);
        rst = 1'b1;
        step();
        n_total++;
        if (in_ready[sel] !== 1'b1) $display("FAIL rst_in_ready[%0d]: got %b, expected 1", sel, in_ready[sel]);
        else n_pass++;
        n_total++;
        if (out_valid[sel] !== 1'b0) $display("FAIL rst_out_valid[%0d]: got %b, expected 0", sel, out_valid[sel]);
        else n_pass++;
        n_total++;
        if (out_last[sel] !== 1'b0) $display("FAIL rst_out_last[%0d]: got %b, expected 0", sel, out_last[sel]);
        else n_pass++;
        n_total++;
        if (out_data[sel] !== 8'h00) $display("FAIL rst_out_data[%0d]: got %02h, expected 00", sel, out_data[sel]);
        else n_pass++;
        rst = 1'b0;
        step();
    endtask

    task automatic test_frame(input int sel, input string name,
                              input logic [7:0] vin [16], input logic [7:0] vexp [16]);
        int ni = 0;
        int no = 0;
        int cyc = 0;
        int acc15 = -100;
        int first_ov = -1;
        out_ready[sel] = 1'b1;
        while (no < 16 && cyc < 64) begin
            in_valid[sel] = (ni < 16);
            in_data[sel]  = (ni < 16) ? vin[ni] : 8'h00;
            if (out_valid[sel]) begin
                if (first_ov < 0) first_ov = cyc;
                n_total++;
                if (out_data[sel] !== vexp[no])
                    $display("FAIL %s_data[%0d] byte %0d: got %02h, expected %02h", name, sel, no, out_data[sel], vexp[no]);
                else n_pass++;
                n_total++;
                if (out_last[sel] !== (no == 15))
                    $display("FAIL %s_last[%0d] byte %0d: got %b, expected %b", name, sel, no, out_last[sel], no == 15);
                else n_pass++;
                no++;
            end
            if (in_valid[sel] && in_ready[sel]) begin
                if (ni == 15) acc15 = cyc;
                ni++;
            end
            step();
            cyc++;
        end
        in_valid[sel]  = 1'b0;
        out_ready[sel] = 1'b0;
        n_total++;
        if (no != 16) $display("FAIL %s_count[%0d]: got %0d bytes, expected 16", name, sel, no);
        else n_pass++;
        n_total++;
        if (first_ov - acc15 != 1 + sel)
            $display("FAIL %s_latency[%0d]: got %0d cycles, expected %0d", name, sel, first_ov - acc15, 1 + sel);
        else n_pass++;
    endtask

    task automatic test_back_to_back(input int sel);
        logic [7:0] fr [48];
        logic [7:0] e;
        int ni = 0;
        int no = 0;
        int cyc = 0;
        exp_q.delete();
        in_buf.delete();
        for (int k = 0; k < 48; k++) fr[k] = 8'($urandom);
        out_ready[sel] = 1'b0;
        for (int k = 0; k < 40; k++) begin
            in_valid[sel] = (ni < 48);
            in_data[sel]  = (ni < 48) ? fr[ni] : 8'h00;
            if (in_valid[sel] && in_ready[sel]) begin
                model_accept(fr[ni]);
                ni++;
            end
            step();
        end
        n_total++;
        if (ni != 32) $display("FAIL b2b_accepted[%0d]: got %0d bytes, expected 32", sel, ni);
        else n_pass++;
        n_total++;
        if (in_ready[sel] !== 1'b0) $display("FAIL b2b_in_ready[%0d]: got %b, expected 0", sel, in_ready[sel]);
        else n_pass++;
        out_ready[sel] = 1'b1;
        while (no < 48 && cyc < 200) begin
            in_valid[sel] = (ni < 48);
            in_data[sel]  = (ni < 48) ? fr[ni] : 8'h00;
            if (out_valid[sel]) begin
                n_total++;
                if (exp_q.size() == 0) begin
                    $display("FAIL b2b_extra[%0d]: got %02h, expected no output", sel, out_data[sel]);
                end else begin
                    e = exp_q.pop_front();
                    if (out_data[sel] !== e)
                        $display("FAIL b2b_data[%0d] byte %0d: got %02h, expected %02h", sel, no, out_data[sel], e);
                    else n_pass++;
                end
                no++;
            end
            if (in_valid[sel] && in_ready[sel]) begin
                model_accept(fr[ni]);
                ni++;
            end
            step();
            cyc++;
        end
        in_valid[sel]  = 1'b0;
        out_ready[sel] = 1'b0;
        n_total++;
        if (no != 48 || ni != 48)
            $display("FAIL b2b_count[%0d]: got %0d out/%0d in, expected 48/48", sel, no, ni);
        else n_pass++;
    endtask

    task automatic test_stream(input int sel);
        logic [7:0] d;
        logic [7:0] e;
        int ni = 0;
        int no = 0;
        int cyc = 0;
        int stalls = 0;
        exp_q.delete();
        in_buf.delete();
        out_ready[sel] = 1'b1;
        while (no < 64 && cyc < 200) begin
            d = 8'($urandom);
            in_valid[sel] = (ni < 64);
            in_data[sel]  = d;
            if (out_valid[sel]) begin
                n_total++;
                if (exp_q.size() == 0) begin
                    $display("FAIL stream_extra[%0d]: got %02h, expected no output", sel, out_data[sel]);
                end else begin
                    e = exp_q.pop_front();
                    if (out_data[sel] !== e)
                        $display("FAIL stream_data[%0d] byte %0d: got %02h, expected %02h", sel, no, out_data[sel], e);
                    else n_pass++;
                end
                no++;
            end
            if (in_valid[sel] && !in_ready[sel]) stalls++;
            if (in_valid[sel] && in_ready[sel]) begin
                model_accept(d);
                ni++;
            end
            step();
            cyc++;
        end
        in_valid[sel]  = 1'b0;
        out_ready[sel] = 1'b0;
        n_total++;
        if (no != 64) $display("FAIL stream_count[%0d]: got %0d bytes, expected 64", sel, no);
        else n_pass++;
        if (sel == 0) begin
            n_total++;
            if (stalls != 0) $display("FAIL stream_bubbles[%0d]: got %0d stalls, expected 0", sel, stalls);
            else n_pass++;
        end
    endtask

    task automatic test_random(input int sel, input int frames);
        logic [7:0] d;
        logic [7:0] held_d;
        logic       held_l;
        logic       held;
        int total;
        int ni = 0;
        int no = 0;
        int cyc = 0;
        total = frames * 16;
        held = 1'b0;
        held_d = 8'h00;
        held_l = 1'b0;
        exp_q.delete();
        in_buf.delete();
        while (no < total && cyc < total * 8) begin
            d = 8'($urandom);
            in_valid[sel]  = (ni < total) && ($urandom_range(0, 3) != 0);
            in_data[sel]   = d;
            out_ready[sel] = ($urandom_range(0, 3) != 0);
            if (held) begin
                n_total++;
                if (out_valid[sel] !== 1'b1 || out_data[sel] !== held_d || out_last[sel] !== held_l)
                    $display("FAIL rand_hold[%0d] cyc %0d: got v=%b d=%02h l=%b, expected v=1 d=%02h l=%b",
                             sel, cyc, out_valid[sel], out_data[sel], out_last[sel], held_d, held_l);
                else n_pass++;
            end
            if (out_valid[sel]) begin
                n_total++;
                if (exp_q.size() == 0) begin
                    $display("FAIL rand_extra[%0d]: got %02h, expected no output", sel, out_data[sel]);
                end else if (out_data[sel] !== exp_q[0] || out_last[sel] !== (no % 16 == 15)) begin
                    $display("FAIL rand_data[%0d] byte %0d: got %02h last=%b, expected %02h last=%b",
                             sel, no, out_data[sel], out_last[sel], exp_q[0], no % 16 == 15);
                end else n_pass++;
                if (out_ready[sel]) begin
                    if (exp_q.size() != 0) void'(exp_q.pop_front());
                    no++;
                end
            end
            held   = out_valid[sel] && !out_ready[sel];
            held_d = out_data[sel];
            held_l = out_last[sel];
            if (in_valid[sel] && in_ready[sel]) begin
                model_accept(d);
                ni++;
            end
            step();
            cyc++;
        end
        in_valid[sel]  = 1'b0;
        out_ready[sel] = 1'b0;
        n_total++;
        if (no != total || ni != total)
            $display("FAIL rand_count[%0d]: got %0d out/%0d in, expected %0d/%0d", sel, no, ni, total, total);
        else n_pass++;
    endtask

    task automatic test_reset_mid(input int sel);
        int ni = 0;
        int ov_cnt = 0;
        out_ready[sel] = 1'b0;
        for (int k = 0; k < 30; k++) begin
            in_valid[sel] = (ni < 23);
            in_data[sel]  = 8'($urandom);
            if (in_valid[sel] && in_ready[sel]) ni++;
            step();
        end
        in_valid[sel] = 1'b0;
        n_total++;
        if (out_valid[sel] !== 1'b1 || ni != 23)
            $display("FAIL mid_preload[%0d]: got valid=%b accepted=%0d, expected 1/23", sel, out_valid[sel], ni);
        else n_pass++;
        rst = 1'b1;
        #1;
        n_total++;
        if (in_ready[sel] !== 1'b1 || out_valid[sel] !== 1'b0 || out_last[sel] !== 1'b0 || out_data[sel] !== 8'h00)
            $display("FAIL mid_rst_outputs[%0d]: got rdy=%b v=%b l=%b d=%02h, expected 1 0 0 00",
                     sel, in_ready[sel], out_valid[sel], out_last[sel], out_data[sel]);
        else n_pass++;
        step();
        rst = 1'b0;
        out_ready[sel] = 1'b1;
        for (int k = 0; k < 20; k++) begin
            if (out_valid[sel]) ov_cnt++;
            step();
        end
        out_ready[sel] = 1'b0;
        n_total++;
        if (ov_cnt != 0) $display("FAIL mid_no_output[%0d]: got %0d valid cycles, expected 0", sel, ov_cnt);
        else n_pass++;
        test_frame(sel, "post_rst", known_in, known_exp);
    endtask

    initial begin
        rst = 1'b1;
        for (int s = 0; s < 2; s++) begin
            in_valid[s]  = 1'b0;
            in_data[s]   = 8'h00;
            out_ready[s] = 1'b0;
        end
        known_in  = '{8'h63, 8'h7c, 8'h77, 8'h7b, 8'hf2, 8'h6b, 8'h6f, 8'hc5,
                      8'h30, 8'h01, 8'h67, 8'h2b, 8'hfe, 8'hd7, 8'hab, 8'h76};
        known_exp = '{8'h00, 8'h0d, 8'h0a, 8'h07, 8'h04, 8'h01, 8'h0e, 8'h0b,
                      8'h08, 8'h05, 8'h02, 8'h0f, 8'h0c, 8'h09, 8'h06, 8'h03};
        zero_in   = '{default: 8'h00};
        zero_exp  = '{default: 8'h52};
        build_tables();
        for (int s = 0; s < 2; s++) begin
            test_reset(s);
            test_frame(s, "known", known_in, known_exp);
            test_frame(s, "zeros", zero_in, zero_exp);
            test_back_to_back(s);
            test_stream(s);
            test_random(s, (s == 1) ? 1000 : 200);
            test_reset_mid(s);
        end
        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
